dmem_lane_ctrl: RTL

Parametrised data memory for the MIPS datapath. Accepts byte/half/word load and store requests over a valid/ready channel and steers bytes to the lane selected by addr[1:0]. Loads return sign- or zero-extended data through an in-order response channel with configurable read latency and backpressure. Misaligned, out-of-range and illegal-size accesses are flagged instead of corrupting memory. It replaces the fixed 4 KB, low-lane-only, combinational-read data memory in the MEM stage.

---
 rtl/dmem_lane_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_lane_ctrl.sv
// Lane-steering data memory for the MIPS MEM stage: byte/half/word loads and stores
// with flagged errors, configurable read latency and an in-order, backpressured response channel.

package dmem_lane_ctrl_pkg;
    typedef struct packed {
        logic        vld;
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;
endpackage

module dmem_lane_ctrl
    import dmem_lane_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned RD_LATENCY  = 1,
    parameter              INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_we
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned FIFO_D = RD_LATENCY + 1;
    localparam int unsigned CNT_W  = $clog2(RD_LATENCY + 2);

    logic [31:0] mem [DEPTH_WORDS];

    logic [ADDR_W-3:0] widx_c;
    logic [IDX_W-1:0]  idx_c;
    logic [1:0]        lane_c;
    logic              in_range_c;
    logic              err_c;
    logic              accept_c;
    logic              pop_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [31:0]       rd_word_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [31:0]       ld_c;
    rsp_t              new_c;
    rsp_t              push_c;
    rsp_t              fifo_q [FIFO_D];
    rsp_t              fifo_d [FIFO_D];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ready_q;
    logic              placed;

    assign lane_c     = req_addr[1:0];
    assign widx_c     = req_addr[ADDR_W-1:2];
    assign idx_c      = req_addr[IDX_W+1:2];
    assign in_range_c = (widx_c >> IDX_W) == '0;
    assign accept_c   = req_valid & ready_q;
    assign pop_c      = fifo_q[0].vld & rsp_ready;

    // Error classification: illegal size, misalignment, out-of-range word index
    always_comb begin
        err_c = 1'b0;
        case (req_size)
            2'b00:   err_c = 1'b0;
            2'b01:   err_c = lane_c[0];
            2'b10:   err_c = |lane_c;
            default: err_c = 1'b1;
        endcase
        if (!in_range_c) err_c = 1'b1;
    end

    // Store lane enables and replicated write data
    always_comb begin
        be_c    = 4'hF;
        wdata_c = req_wdata;
        case (req_size)
            2'b00: begin
                be_c    = 4'b0001 << lane_c;
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = lane_c[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{req_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'hF;
                wdata_c = req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept_c && req_we && !err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) mem[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
            end
        end
    end

    // Load lane extraction and extension
    assign rd_word_c = mem[idx_c];
    assign byte_c    = rd_word_c[{lane_c, 3'b000} +: 8];
    assign half_c    = lane_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];

    always_comb begin
        ld_c = rd_word_c;
        case (req_size)
            2'b00:   ld_c = {{24{req_signed & byte_c[7]}}, byte_c};
            2'b01:   ld_c = {{16{req_signed & half_c[15]}}, half_c};
            default: ld_c = rd_word_c;
        endcase
    end

    always_comb begin
        new_c       = '0;
        new_c.vld   = accept_c;
        new_c.we    = req_we;
        new_c.err   = err_c;
        new_c.rdata = (!req_we && !err_c) ? ld_c : 32'h0;
    end

    // Non-stalling delay line; the FIFO itself provides the last register stage
    if (RD_LATENCY == 1) begin : g_nopipe
        assign push_c = new_c;
    end else begin : g_pipe
        rsp_t pipe_q [RD_LATENCY-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(RD_LATENCY) - 1; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= new_c;
                for (int i = 1; i < int'(RD_LATENCY) - 1; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign push_c = pipe_q[RD_LATENCY-2];
    end

    // Shift-out FIFO keeps the head in a fixed register so outputs are registered
    always_comb begin
        fifo_d = fifo_q;
        placed = 1'b0;
        if (pop_c) begin
            for (int i = 0; i < int'(FIFO_D) - 1; i++) fifo_d[i] = fifo_q[i+1];
            fifo_d[FIFO_D-1] = '0;
        end
        for (int i = 0; i < int'(FIFO_D); i++) begin
            if (push_c.vld && !placed && !fifo_d[i].vld) begin
                fifo_d[i] = push_c;
                placed    = 1'b1;
            end
        end
    end

    assign cnt_d = cnt_q + CNT_W'(accept_c) - CNT_W'(pop_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_D); i++) fifo_q[i] <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            fifo_q  <= fifo_d;
            cnt_q   <= cnt_d;
            ready_q <= cnt_d < CNT_W'(FIFO_D);
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = fifo_q[0].vld;
    assign rsp_rdata = fifo_q[0].rdata;
    assign rsp_err   = fifo_q[0].err;
    assign rsp_we    = fifo_q[0].we;

endmodule
